// File: rtl/sirv_qspi_flash_rdpack.sv
// sirv_qspi_flash_rdpack
// ICB read front-end for the QSPI flash-map engine. Each legal read command
// becomes a sequence of single-byte address requests. The returned bytes are
// packed into a 32-bit word by lane, and one ICB response goes back per command.
// Writes and misaligned or illegal-size reads get an immediate error response
// and never touch the flash.
// Optional build macro: SIRV_QSPI_RDPACK_TIMEOUT_EN. When it is defined, a
// data-return watchdog aborts the command after TO_CYC idle DATA cycles.
module sirv_qspi_flash_rdpack #(
    parameter int AW     = 29,
    parameter int TO_CYC = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_icb_cmd_valid,
    output logic        i_icb_cmd_ready,
    input  logic [31:0] i_icb_cmd_addr,
    input  logic        i_icb_cmd_read,
    input  logic [1:0]  i_icb_cmd_size,
    output logic        i_icb_rsp_valid,
    input  logic        i_icb_rsp_ready,
    output logic [31:0] i_icb_rsp_rdata,
    output logic        i_icb_rsp_err,
    output logic        f_addr_valid,
    input  logic        f_addr_ready,
    output logic [31:0] f_addr_next,
    output logic [31:0] f_addr_hold,
    input  logic        f_data_valid,
    output logic        f_data_ready,
    input  logic [7:0]  f_data_bits
);

    // Keeps the flash byte address inside the 2^AW window.
    localparam logic [63:0] MASK64    = (64'd1 << AW) - 64'd1;
    localparam logic [31:0] ADDR_MASK = MASK64[31:0];

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_RSP
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] addr_q;      // command address, as presented on the bus
    logic [1:0]  size_q;      // command size code
    logic [1:0]  idx_q;       // index of the byte currently being fetched
    logic [31:0] hold_q;      // last byte address handed to the flash map
    logic [31:0] data_q;      // packed read word
    logic        err_q;       // error flag returned with the response

    logic        cmd_hsk;
    logic        cmd_err;
    logic        addr_hsk;
    logic        data_hsk;
    logic        beat_last;
    logic        timeout;
    logic [1:0]  last_idx;
    logic [1:0]  lane;
    logic [31:0] req_addr;

    assign cmd_hsk  = i_icb_cmd_valid & i_icb_cmd_ready;
    assign addr_hsk = (state == S_ADDR) & f_addr_ready;
    assign data_hsk = (state == S_DATA) & f_data_valid;

    // Reject writes, the illegal size code and reads not aligned to their size.
    assign cmd_err = ~i_icb_cmd_read
                   | (i_icb_cmd_size == 2'd3)
                   | ((i_icb_cmd_size == 2'd1) & i_icb_cmd_addr[0])
                   | ((i_icb_cmd_size == 2'd2) & (|i_icb_cmd_addr[1:0]));

    // The last byte index is N-1, which is 0, 1 or 3 for byte, half or word.
    assign last_idx  = {size_q[1], size_q[1] | size_q[0]};
    assign beat_last = (idx_q == last_idx);
    assign lane      = addr_q[1:0] + idx_q;
    assign req_addr  = (addr_q & ADDR_MASK) + {30'd0, idx_q};

`ifdef SIRV_QSPI_RDPACK_TIMEOUT_EN
    localparam logic [9:0] TO_LIM = 10'(TO_CYC);

    logic [9:0] to_cnt;

    // A beat in the same cycle as the limit wins, so timeout needs an idle cycle.
    assign timeout = (state == S_DATA) & ~f_data_valid & (to_cnt == TO_LIM);

    // Watchdog: cleared on entry to DATA, counts DATA cycles without a beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (addr_hsk) begin
            to_cnt <= '0;
        end else if ((state == S_DATA) && !f_data_valid && !timeout) begin
            to_cnt <= to_cnt + 10'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: the default assignment first means no path leaves state_nxt unassigned, so no latch.
        state_nxt = state;
        case (state)
            S_IDLE: if (cmd_hsk)         state_nxt = cmd_err ? S_RSP : S_ADDR;
            S_ADDR: if (f_addr_ready)    state_nxt = S_DATA;
            S_DATA: begin
                if (f_data_valid)        state_nxt = beat_last ? S_RSP : S_ADDR;
                else if (timeout)        state_nxt = S_RSP;
            end
            S_RSP:  if (i_icb_rsp_ready) state_nxt = S_IDLE;
            default:                     state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from the state. Command ready is also low while reset is asserted.
    always_comb begin
        i_icb_cmd_ready = (state == S_IDLE) & rst_n;
        i_icb_rsp_valid = (state == S_RSP);
        i_icb_rsp_rdata = (state == S_RSP) ? data_q : 32'd0;
        i_icb_rsp_err   = (state == S_RSP) & err_q;
        f_addr_valid    = (state == S_ADDR);
        f_addr_next     = (state == S_ADDR) ? req_addr : 32'd0;
        f_addr_hold     = hold_q;
        f_data_ready    = (state == S_DATA);
    end

    // Datapath: command capture, hold tracking and byte packing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data word is a plain register rather than a memory, so it resets to zero.
            addr_q <= '0;
            size_q <= '0;
            idx_q  <= '0;
            hold_q <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (cmd_hsk) begin
                addr_q <= i_icb_cmd_addr;
                size_q <= i_icb_cmd_size;
                idx_q  <= '0;
                data_q <= '0;
                err_q  <= cmd_err;
            end
            if (addr_hsk) begin
                hold_q <= f_addr_next;
            end
            if (data_hsk) begin
                data_q[{lane, 3'b000} +: 8] <= f_data_bits;
                idx_q                       <= idx_q + 2'd1;
            end
            if (timeout) begin
                // Forget the open flash transaction so the next access starts fresh.
                hold_q <= '0;
                err_q  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sirv_qspi_flash_rdpack.sv
// Testbench for sirv_qspi_flash_rdpack. It runs directed vectors from a table,
// a few hand-written sequences for reset and timeout, and randomized commands.
// All expected values come from a reference model of the command rules.
module tb_sirv_qspi_flash_rdpack;

    localparam logic [31:0] AMASK = 32'h1FFF_FFFF;
`ifdef SIRV_QSPI_RDPACK_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 1023;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_icb_cmd_valid;
    logic        i_icb_cmd_ready;
    logic [31:0] i_icb_cmd_addr;
    logic        i_icb_cmd_read;
    logic [1:0]  i_icb_cmd_size;
    logic        i_icb_rsp_valid;
    logic        i_icb_rsp_ready;
    logic [31:0] i_icb_rsp_rdata;
    logic        i_icb_rsp_err;
    logic        f_addr_valid;
    logic        f_addr_ready;
    logic [31:0] f_addr_next;
    logic [31:0] f_addr_hold;
    logic        f_data_valid;
    logic        f_data_ready;
    logic [7:0]  f_data_bits;

    always #5 clk = ~clk;

    sirv_qspi_flash_rdpack #(.AW(29), .TO_CYC(TO)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_icb_cmd_valid (i_icb_cmd_valid),
        .i_icb_cmd_ready (i_icb_cmd_ready),
        .i_icb_cmd_addr  (i_icb_cmd_addr),
        .i_icb_cmd_read  (i_icb_cmd_read),
        .i_icb_cmd_size  (i_icb_cmd_size),
        .i_icb_rsp_valid (i_icb_rsp_valid),
        .i_icb_rsp_ready (i_icb_rsp_ready),
        .i_icb_rsp_rdata (i_icb_rsp_rdata),
        .i_icb_rsp_err   (i_icb_rsp_err),
        .f_addr_valid    (f_addr_valid),
        .f_addr_ready    (f_addr_ready),
        .f_addr_next     (f_addr_next),
        .f_addr_hold     (f_addr_hold),
        .f_data_valid    (f_data_valid),
        .f_data_ready    (f_data_ready),
        .f_data_bits     (f_data_bits)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_hold  = 32'd0;     // model of the flash hold address
    logic [31:0] cap_next [4];
    logic [31:0] cap_hold [4];

    typedef struct {
        string       tag;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        rd;
        logic [31:0] bytes;   // byte k of the return stream is bytes[8k+7:8k]
        int          ar_dly;
        int          rr_dly;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: error rule, byte count and lane placement of each byte.
    task automatic model(input logic [31:0] a, input logic [1:0] sz, input logic rd,
                         input logic [31:0] bytes, output logic e_err,
                         output logic [31:0] e_rdata, output int e_n);
        e_err = !rd || sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
        e_n   = e_err ? 0 : (1 << sz);
        e_rdata = 32'd0;
        for (int k = 0; k < e_n; k++) begin
            int ln;
            ln = (int'(a[1:0]) + k) % 4;
            e_rdata[8*ln +: 8] = bytes[8*k +: 8];
        end
    endtask

    // Drives one command and acts as the flash map and the response sink.
    task automatic run_cmd(input logic [31:0] a, input logic [1:0] sz, input logic rd,
                           input logic [31:0] bytes, input int ar_dly, input int rr_dly,
                           input int max_beats, output logic [31:0] rdata, output logic err,
                           output int n_addr, output int lat, output bit stable, output bit done);
        int ref_cyc, nbeat, await_c, rwait;
        bit in_addr, in_rsp;
        ref_cyc = 0; nbeat = 0; await_c = 0; rwait = 0; in_addr = 0; in_rsp = 0;
        rdata = 32'd0; err = 1'b0; n_addr = 0; lat = -1; stable = 1; done = 0;
        @(negedge clk);
        i_icb_cmd_valid = 1'b1;
        i_icb_cmd_addr  = a;
        i_icb_cmd_size  = sz;
        i_icb_cmd_read  = rd;
        @(posedge clk);
        @(negedge clk);
        i_icb_cmd_valid = 1'b0;
        i_icb_cmd_addr  = $urandom;
        for (int cyc = 1; cyc <= 300 && !done; cyc++) begin
            f_addr_ready    = 1'b0;
            f_data_valid    = 1'($urandom_range(0, 1));   // noise, must be ignored outside DATA
            f_data_bits     = 8'hEE;
            i_icb_rsp_ready = 1'b0;
            if (f_addr_valid) begin
                if (!in_addr) begin
                    in_addr = 1;
                    await_c = 0;
                    if (n_addr < 4) begin
                        cap_next[n_addr] = f_addr_next;
                        cap_hold[n_addr] = f_addr_hold;
                    end
                end else if (n_addr < 4 && (f_addr_next !== cap_next[n_addr] ||
                                            f_addr_hold !== cap_hold[n_addr])) begin
                    stable = 0;
                end
                if (await_c >= ar_dly) begin
                    f_addr_ready = 1'b1;
                    n_addr++;
                    in_addr = 0;
                end
                await_c++;
            end
            if (f_data_ready) begin
                f_data_valid = 1'b0;
                if (nbeat < max_beats) begin
                    f_data_valid = 1'b1;
                    f_data_bits  = bytes[8*nbeat +: 8];
                    nbeat++;
                    ref_cyc = cyc;
                end
            end
            if (i_icb_rsp_valid) begin
                if (!in_rsp) begin
                    in_rsp = 1;
                    rwait  = 0;
                    lat    = cyc - ref_cyc;
                    rdata  = i_icb_rsp_rdata;
                    err    = i_icb_rsp_err;
                end else if (rdata !== i_icb_rsp_rdata || err !== i_icb_rsp_err) begin
                    stable = 0;
                end
                if (rwait >= rr_dly) begin
                    i_icb_rsp_ready = 1'b1;
                    done = 1;
                end
                rwait++;
            end
            @(posedge clk);
            @(negedge clk);
        end
        f_addr_ready    = 1'b0;
        f_data_valid    = 1'b0;
        i_icb_rsp_ready = 1'b0;
    endtask

    // Runs one command and compares everything observable against the model.
    task automatic check_txn(input string tag, input logic [31:0] a, input logic [1:0] sz,
                             input logic rd, input logic [31:0] bytes, input int ar,
                             input int rr, output logic [31:0] rdata, output logic err);
        logic [31:0] e_rdata, base, prev;
        logic        e_err;
        int          e_n, n_addr, lat;
        bit          stable, done;
        model(a, sz, rd, bytes, e_err, e_rdata, e_n);
        run_cmd(a, sz, rd, bytes, ar, rr, 4, rdata, err, n_addr, lat, stable, done);
        check({tag, ".done"},    32'(done), 32'd1);
        check({tag, ".err"},     32'(err), 32'(e_err));
        check({tag, ".rdata"},   rdata, e_rdata);
        check({tag, ".n_addr"},  32'(n_addr), 32'(e_n));
        check({tag, ".latency"}, 32'(lat), 32'd1);
        check({tag, ".stable"},  32'(stable), 32'd1);
        base = a & AMASK;
        prev = m_hold;
        for (int k = 0; k < e_n; k++) begin
            check($sformatf("%s.next%0d", tag, k), cap_next[k], base + 32'(k));
            check($sformatf("%s.hold%0d", tag, k), cap_hold[k], prev);
            prev = base + 32'(k);
        end
        check({tag, ".one_rsp"},   32'(i_icb_rsp_valid), 32'd0);
        check({tag, ".cmd_ready"}, 32'(i_icb_cmd_ready), 32'd1);
        if (!e_err) m_hold = base + 32'(e_n - 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".cmd_ready"}, 32'(i_icb_cmd_ready), 32'd0);
        check({tag, ".rsp_valid"}, 32'(i_icb_rsp_valid), 32'd0);
        check({tag, ".rdata"},     i_icb_rsp_rdata, 32'd0);
        check({tag, ".err"},       32'(i_icb_rsp_err), 32'd0);
        check({tag, ".addr_valid"},32'(f_addr_valid), 32'd0);
        check({tag, ".next"},      f_addr_next, 32'd0);
        check({tag, ".hold"},      f_addr_hold, 32'd0);
        check({tag, ".data_ready"},32'(f_data_ready), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rdata;
        logic        err;
        rst_n = 1'b0;
        i_icb_cmd_valid = 1'b0; i_icb_cmd_addr = 32'd0; i_icb_cmd_read = 1'b0;
        i_icb_cmd_size = 2'd0; i_icb_rsp_ready = 1'b0; f_addr_ready = 1'b0;
        f_data_valid = 1'b0; f_data_bits = 8'd0;

        vecs[0] = '{"word",      32'h2000_0100, 2'd2, 1'b1, 32'h4433_2211, 0, 0, 1'b0, 32'h4433_2211};
        vecs[1] = '{"byte",      32'h2000_0203, 2'd0, 1'b1, 32'h0000_00A5, 0, 0, 1'b0, 32'hA500_0000};
        vecs[2] = '{"write",     32'h2000_0100, 2'd2, 1'b0, 32'h1234_5678, 0, 0, 1'b1, 32'h0000_0000};
        vecs[3] = '{"mis_word",  32'h2000_0002, 2'd2, 1'b1, 32'h1234_5678, 0, 0, 1'b1, 32'h0000_0000};
        vecs[4] = '{"size3",     32'h2000_0000, 2'd3, 1'b1, 32'h1234_5678, 0, 1, 1'b1, 32'h0000_0000};
        vecs[5] = '{"mis_half",  32'h2000_0011, 2'd1, 1'b1, 32'h1234_5678, 0, 0, 1'b1, 32'h0000_0000};
        vecs[6] = '{"backpress", 32'h2000_0104, 2'd2, 1'b1, 32'hDDCC_BBAA, 5, 3, 1'b0, 32'hDDCC_BBAA};
        vecs[7] = '{"top_half",  32'h3FFF_FFFE, 2'd1, 1'b1, 32'h0000_6B5A, 0, 0, 1'b0, 32'h6B5A_0000};

        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset.cmd_ready", 32'(i_icb_cmd_ready), 32'd1);

        foreach (vecs[i]) begin
            check_txn(vecs[i].tag, vecs[i].addr, vecs[i].size, vecs[i].rd, vecs[i].bytes,
                      vecs[i].ar_dly, vecs[i].rr_dly, rdata, err);
            check({vecs[i].tag, ".tbl_err"},   32'(err), 32'(vecs[i].exp_err));
            check({vecs[i].tag, ".tbl_rdata"}, rdata, vecs[i].exp_rdata);
        end

        // Async reset in the DATA phase of a word read, after one byte was packed.
        @(negedge clk);
        i_icb_cmd_valid = 1'b1; i_icb_cmd_addr = 32'h2000_0040;
        i_icb_cmd_size = 2'd2; i_icb_cmd_read = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_icb_cmd_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_seq.addr_valid%0d", k), 32'(f_addr_valid), 32'd1);
            f_addr_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            f_addr_ready = 1'b0;
            check($sformatf("rst_seq.data_ready%0d", k), 32'(f_data_ready), 32'd1);
            if (k == 0) begin
                f_data_valid = 1'b1; f_data_bits = 8'h77;
                @(posedge clk);
                @(negedge clk);
                f_data_valid = 1'b0;
            end
        end
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        m_hold = 32'd0;
        check_txn("after_rst", 32'h2000_0010, 2'd1, 1'b1, 32'h0000_CCBB, 0, 0, rdata, err);
        check("after_rst.exact", rdata, 32'h0000_CCBB);

`ifdef SIRV_QSPI_RDPACK_TIMEOUT_EN
        begin
            int n_addr, lat;
            bit stable, done;
            run_cmd(32'h2000_0300, 2'd2, 1'b1, 32'h0000_0201, 0, 0, 2,
                    rdata, err, n_addr, lat, stable, done);
            check("timeout.done",  32'(done), 32'd1);
            check("timeout.err",   32'(err), 32'd1);
            check("timeout.rdata", rdata, 32'h0000_0201);
            check("timeout.hold",  f_addr_hold, 32'd0);
            m_hold = 32'd0;
        end
`endif

        for (int r = 0; r < 40; r++) begin
            logic [31:0] a;
            logic [1:0]  sz;
            logic        rd;
            a  = $urandom;
            sz = 2'($urandom_range(0, 3));
            rd = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            if (r % 5 == 0) begin
                // Continue just after the last byte so the hold address lines up.
                a  = {3'b001, m_hold[28:0]} + 32'd1;
                sz = 2'd0;
                rd = 1'b1;
            end
            check_txn($sformatf("rnd%0d", r), a, sz, rd, $urandom,
                      $urandom_range(0, 3), $urandom_range(0, 3), rdata, err);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
